agg_fetch_sched: RTL

AGG_FETCH_SCHED -- requirements
Module: agg_fetch_sched

---
 rtl/agg_fetch_sched.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/agg_fetch_sched.sv
// Ordered fetch scheduler: issues table reads for LRU misses and releases every
// item downstream in input order, holding each miss until its read completes.
module agg_fetch_sched #(
    parameter int unsigned KEY_BITS        = 32,
    parameter int unsigned ADDR_BITS       = 64,
    parameter int unsigned ENTRY_BYTES     = 64,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned ORDER_DEPTH     = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic                 s_meta_valid,
    output logic                 s_meta_ready,
    input  logic [KEY_BITS-1:0]  s_meta_key,
    input  logic                 s_meta_last,
    input  logic                 s_meta_hit,
    output logic                 m_rd_valid,
    input  logic                 m_rd_ready,
    output logic [ADDR_BITS-1:0] m_rd_addr,
    output logic [31:0]          m_rd_len,
    input  logic                 rd_done,
    output logic                 m_meta_valid,
    input  logic                 m_meta_ready,
    output logic [KEY_BITS-1:0]  m_meta_key,
    output logic                 m_meta_last,
    output logic                 m_meta_hit,
    output logic                 done,
    output logic                 err,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
);
    localparam int unsigned OFF_BITS = $clog2(ENTRY_BYTES);
    localparam int unsigned PTR_BITS = $clog2(ORDER_DEPTH);
    localparam int unsigned CNT_BITS = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned ENT_BITS = KEY_BITS + 2;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t               state_q;
    logic [ENT_BITS-1:0]  queue_q [ORDER_DEPTH];
    logic [PTR_BITS:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_BITS-1:0]  outstanding_q, outstanding_d;
    logic [CNT_BITS-1:0]  credits_q, credits_d;
    logic                 rd_valid_q;
    logic [ADDR_BITS-1:0] rd_addr_q;
    logic                 out_valid_q;
    logic [KEY_BITS-1:0]  out_key_q;
    logic                 out_last_q, out_hit_q;
    logic                 done_q, err_q;
    logic [31:0]          hit_cnt_q, miss_cnt_q;

    logic                 q_empty, q_full, head_ok, pop, rel_miss;
    logic                 accept, acc_miss, credit_inc, drain_ok;
    logic [ENT_BITS-1:0]  head;

    // Handshake, eligibility and counter next-state decode
    always_comb begin
        q_empty    = (wr_ptr_q == rd_ptr_q);
        q_full     = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                     (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);
        head       = queue_q[rd_ptr_q[PTR_BITS-1:0]];
        head_ok    = !q_empty && (head[0] || (credits_q != '0));
        pop        = head_ok && (!out_valid_q || m_meta_ready);
        rel_miss   = pop && !head[0];
        s_meta_ready = !areset && (state_q == RUN) && !q_full &&
                       (!rd_valid_q || m_rd_ready) &&
                       (outstanding_q < CNT_BITS'(MAX_OUTSTANDING));
        accept     = s_meta_valid && s_meta_ready;
        acc_miss   = accept && !s_meta_hit;
        // A completion with no read in flight is a protocol error and is dropped
        credit_inc = rd_done && (credits_q != outstanding_q);
        drain_ok   = q_empty && (!out_valid_q || m_meta_ready) && (outstanding_q == '0);

        outstanding_d = outstanding_q;
        if (acc_miss && !rel_miss) begin
            outstanding_d = outstanding_q + CNT_BITS'(1);
        end else if (!acc_miss && rel_miss) begin
            outstanding_d = outstanding_q - CNT_BITS'(1);
        end

        credits_d = credits_q;
        if (credit_inc && !rel_miss) begin
            credits_d = credits_q + CNT_BITS'(1);
        end else if (!credit_inc && rel_miss) begin
            credits_d = credits_q - CNT_BITS'(1);
        end
    end

    // Control state, pointers, counters and FSM
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= RUN;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            credits_q     <= '0;
            rd_valid_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            credits_q     <= credits_d;
            done_q        <= 1'b0;
            if (rd_done && !credit_inc) begin
                err_q <= 1'b1;
            end
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + (PTR_BITS + 1)'(1);
                if (s_meta_hit) begin
                    hit_cnt_q <= hit_cnt_q + 32'd1;
                end else begin
                    miss_cnt_q <= miss_cnt_q + 32'd1;
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (PTR_BITS + 1)'(1);
            end
            if (acc_miss) begin
                rd_valid_q <= 1'b1;
            end else if (m_rd_ready) begin
                rd_valid_q <= 1'b0;
            end
            if (pop) begin
                out_valid_q <= 1'b1;
            end else if (m_meta_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                RUN: begin
                    if (accept && s_meta_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_ok) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // Payload storage needs no reset; valids and pointers qualify it
    always_ff @(posedge aclk) begin
        if (accept) begin
            queue_q[wr_ptr_q[PTR_BITS-1:0]] <= {s_meta_key, s_meta_last, s_meta_hit};
        end
        if (acc_miss) begin
            rd_addr_q <= base_addr + (ADDR_BITS'(s_meta_key) << OFF_BITS);
        end
        if (pop) begin
            out_key_q  <= head[ENT_BITS-1:2];
            out_last_q <= head[1];
            out_hit_q  <= head[0];
        end
    end

    assign m_rd_valid   = rd_valid_q;
    assign m_rd_addr    = rd_addr_q;
    assign m_rd_len     = 32'(ENTRY_BYTES);
    assign m_meta_valid = out_valid_q;
    assign m_meta_key   = out_key_q;
    assign m_meta_last  = out_last_q;
    assign m_meta_hit   = out_hit_q;
    assign done         = done_q;
    assign err          = err_q;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;

endmodule
